// File: rtl/dmg_irq_ctrl_pkg.sv
// Shared definitions for the DMG interrupt controller: source indices, vector
// layout, dispatch state encoding and register addresses.
package dmg_irq_pkg;

   localparam int NUM_SRC = 5;

   typedef enum logic [2:0] {
      SRC_VBLANK = 3'd0,
      SRC_STAT   = 3'd1,
      SRC_TIMER  = 3'd2,
      SRC_SERIAL = 3'd3,
      SRC_JOYPAD = 3'd4
   } irq_src_e;

   localparam logic [7:0] VEC_BASE   = 8'h40;
   localparam logic [7:0] VEC_STRIDE = 8'h08;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } irq_state_e;

   localparam logic [15:0] ADDR_IF = 16'hFF0F;
   localparam logic [15:0] ADDR_IE = 16'hFFFF;

   // Dispatch vector for a source index; index 0 maps to VEC_BASE.
   function automatic logic [7:0] vec_of(input logic [2:0] idx);
      return VEC_BASE + ({5'b00000, idx} * VEC_STRIDE);
   endfunction

endpackage

// File: rtl/dmg_irq_ctrl_if.sv
// CPU-side bus of the interrupt controller: register access, IME strobes,
// dispatch handshake and per-source interrupt pulses.
interface dmg_irq_ctrl_if;
   logic [4:0] irq_pulse;
   logic       sel_if;
   logic       sel_ie;
   logic       wr_en;
   logic [7:0] wr_data;
   logic [7:0] rd_data;
   logic       ei;
   logic       di;
   logic       int_ack;
   logic       int_req;
   logic [7:0] int_vec;
   logic       wake;
   logic       ime;

   // int_req is a level held until the single-cycle int_ack is sampled on a
   // rising edge; int_vec is only meaningful while int_req is high.
   modport master (
      output irq_pulse, sel_if, sel_ie, wr_en, wr_data, ei, di, int_ack,
      input  rd_data, int_req, int_vec, wake, ime
   );

   modport slave (
      input  irq_pulse, sel_if, sel_ie, wr_en, wr_data, ei, di, int_ack,
      output rd_data, int_req, int_vec, wake, ime
   );
endinterface

// File: rtl/dmg_irq_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder over the five pending interrupt sources.
module irq_prio_enc
   import dmg_irq_pkg::*;
(
   input  logic [4:0] pending,
   output logic       valid,
   output logic [2:0] idx,
   output logic [7:0] vec
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      valid = 1'b0;
      idx   = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pending[i]) begin
            valid = 1'b1;
            idx   = 3'(i);
         end
      end
   end

   assign vec = valid ? vec_of(idx) : 8'h00;

endmodule

// File: rtl/dmg_irq_ctrl.sv
// DMG interrupt controller: IF/IE registers, IME with delayed EI, and the
// IDLE/REQ/ACK dispatch handshake towards the CPU sequencer.
module dmg_irq_ctrl
   import dmg_irq_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   dmg_irq_ctrl_if.slave  bus,
   output logic [1:0]     dbg_state
);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_REQ  = ST_REQ;
   localparam logic [1:0] S_ACK  = ST_ACK;

   logic [4:0] if_q;
   logic [7:0] ie_q;
   logic       ime_q;
   logic       ei_arm_q;
   logic [1:0] state_q;
   logic       int_req_q;
   logic [7:0] int_vec_q;

   logic [4:0] pending;
   logic       prio_valid;
   logic [2:0] prio_idx;
   logic [7:0] prio_vec;
   logic [4:0] prio_onehot;
   logic       wr_if;
   logic       wr_ie;
   logic       ack_take;
   logic [4:0] ack_clr;
   logic [4:0] if_base;

   assign pending = if_q & ie_q[4:0];
   assign wr_if   = bus.wr_en & bus.sel_if;
   assign wr_ie   = bus.wr_en & bus.sel_ie;

   irq_prio_enc u_prio (
      .pending (pending),
      .valid   (prio_valid),
      .idx     (prio_idx),
      .vec     (prio_vec)
   );

   // An acknowledge with nothing pending (late IE/IF change) clears no flag.
   assign ack_take    = (state_q == S_REQ) && bus.int_ack;
   assign prio_onehot = prio_valid ? (5'b00001 << prio_idx) : 5'b00000;
   assign ack_clr     = ack_take ? prio_onehot : 5'b00000;
   assign if_base     = wr_if ? bus.wr_data[4:0] : if_q;

   // Pulses are OR-ed in last so a same-cycle set beats any clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_q <= 5'b00000;
      end else begin
         if_q <= (if_base & ~ack_clr) | bus.irq_pulse;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ie_q <= 8'h00;
      end else if (wr_ie) begin
         ie_q <= bus.wr_data;
      end
   end

   // EI arms on the first edge and enables IME on the second; DI or a taken
   // acknowledge disarms and disables at once, overriding a concurrent EI.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ime_q    <= 1'b0;
         ei_arm_q <= 1'b0;
      end else if (bus.di || ack_take) begin
         ime_q    <= 1'b0;
         ei_arm_q <= 1'b0;
      end else begin
         if (ei_arm_q) begin
            ime_q <= 1'b1;
         end
         ei_arm_q <= bus.ei;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         int_req_q <= 1'b0;
         int_vec_q <= 8'h00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ime_q && (pending != 5'b00000)) begin
                  state_q   <= S_REQ;
                  int_req_q <= 1'b1;
                  int_vec_q <= prio_vec;
               end
            end
            S_REQ: begin
               // An acknowledge commits the dispatch even if DI arrives with it.
               if (bus.int_ack) begin
                  state_q   <= S_ACK;
                  int_req_q <= 1'b0;
               end else if (bus.di) begin
                  state_q   <= S_IDLE;
                  int_req_q <= 1'b0;
               end else begin
                  int_vec_q <= prio_vec;
               end
            end
            S_ACK: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q   <= S_IDLE;
               int_req_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      bus.rd_data = 8'hFF;
      if (bus.sel_if) begin
         bus.rd_data = {3'b111, if_q};
      end else if (bus.sel_ie) begin
         bus.rd_data = ie_q;
      end
   end

   assign bus.int_req = int_req_q;
   assign bus.int_vec = int_vec_q;
   assign bus.wake    = |pending;
   assign bus.ime     = ime_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_dmg_irq_ctrl.sv
// Directed bench for dmg_irq_ctrl: dispatch, priority, late cancel, set-wins,
// EI/DI timing and asynchronous reset.
module tb_dmg_irq_ctrl;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;
   int         n_chk;
   int         n_err;
   logic [7:0] rd;

   dmg_irq_ctrl_if bus ();

   dmg_irq_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input bit to_if, input logic [7:0] data);
      bus.sel_if  = to_if;
      bus.sel_ie  = ~to_if;
      bus.wr_en   = 1'b1;
      bus.wr_data = data;
      tick();
      bus.sel_if  = 1'b0;
      bus.sel_ie  = 1'b0;
      bus.wr_en   = 1'b0;
   endtask

   task automatic read_reg(input bit from_if, input bit from_ie, output logic [7:0] data);
      bus.sel_if = from_if;
      bus.sel_ie = from_ie;
      #1;
      data = bus.rd_data;
      bus.sel_if = 1'b0;
      bus.sel_ie = 1'b0;
   endtask

   task automatic strobe_ei();
      bus.ei = 1'b1;
      tick();
      bus.ei = 1'b0;
   endtask

   task automatic strobe_ack();
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_chk++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", bus.int_req); end
      n_chk++; if (bus.int_vec !== 8'h00) begin n_err++; $display("FAIL rst_vec: got %h want 00", bus.int_vec); end
      n_chk++; if (bus.ime !== 1'b0) begin n_err++; $display("FAIL rst_ime: got %b want 0", bus.ime); end
      n_chk++; if (bus.wake !== 1'b0) begin n_err++; $display("FAIL rst_wake: got %b want 0", bus.wake); end
      n_chk++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
      read_reg(1'b1, 1'b0, rd);
      n_chk++; if (rd !== 8'hE0) begin n_err++; $display("FAIL rst_if: got %h want e0", rd); end
      read_reg(1'b0, 1'b1, rd);
      n_chk++; if (rd !== 8'h00) begin n_err++; $display("FAIL rst_ie: got %h want 00", rd); end
      read_reg(1'b0, 1'b0, rd);
      n_chk++; if (rd !== 8'hFF) begin n_err++; $display("FAIL rd_none: got %h want ff", rd); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic_dispatch();
      write_reg(1'b0, 8'h04);
      strobe_ei();
      bus.irq_pulse = 5'b00100;
      tick();
      bus.irq_pulse = 5'b00000;
      n_chk++; if (bus.ime !== 1'b1) begin n_err++; $display("FAIL basic_ime_on: got %b want 1", bus.ime); end
      n_chk++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL basic_lat1: got %b want 0", bus.int_req); end
      n_chk++; if (bus.wake !== 1'b1) begin n_err++; $display("FAIL basic_wake: got %b want 1", bus.wake); end
      tick();
      n_chk++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL basic_req: got %b want 1", bus.int_req); end
      n_chk++; if (bus.int_vec !== 8'h50) begin n_err++; $display("FAIL basic_vec: got %h want 50", bus.int_vec); end
      n_chk++; if (dbg_state !== S_REQ) begin n_err++; $display("FAIL basic_state_req: got %0d want 1", dbg_state); end
      strobe_ack();
      n_chk++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL basic_req_drop: got %b want 0", bus.int_req); end
      n_chk++; if (bus.int_vec !== 8'h50) begin n_err++; $display("FAIL basic_vec_hold: got %h want 50", bus.int_vec); end
      n_chk++; if (bus.ime !== 1'b0) begin n_err++; $display("FAIL basic_ime_off: got %b want 0", bus.ime); end
      n_chk++; if (dbg_state !== S_ACK) begin n_err++; $display("FAIL basic_state_ack: got %0d want 2", dbg_state); end
      read_reg(1'b1, 1'b0, rd);
      n_chk++; if (rd !== 8'hE0) begin n_err++; $display("FAIL basic_if_clr: got %h want e0", rd); end
      tick();
      n_chk++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL basic_state_idle: got %0d want 0", dbg_state); end
      n_chk++; if (bus.int_vec !== 8'h50) begin n_err++; $display("FAIL basic_vec_ack: got %h want 50", bus.int_vec); end
   endtask

   task automatic test_priority();
      write_reg(1'b0, 8'h1F);
      write_reg(1'b1, 8'h1A);
      n_chk++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL prio_no_ime: got %b want 0", bus.int_req); end
      strobe_ei();
      tick();
      tick();
      n_chk++; if (bus.int_vec !== 8'h48) begin n_err++; $display("FAIL prio_vec_stat: got %h want 48", bus.int_vec); end
      strobe_ack();
      read_reg(1'b1, 1'b0, rd);
      n_chk++; if (rd !== 8'hF8) begin n_err++; $display("FAIL prio_if_after1: got %h want f8", rd); end
      tick();
      strobe_ei();
      tick();
      tick();
      n_chk++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL prio_req2: got %b want 1", bus.int_req); end
      n_chk++; if (bus.int_vec !== 8'h58) begin n_err++; $display("FAIL prio_vec_serial: got %h want 58", bus.int_vec); end
      strobe_ack();
      read_reg(1'b1, 1'b0, rd);
      n_chk++; if (rd !== 8'hF0) begin n_err++; $display("FAIL prio_if_after2: got %h want f0", rd); end
      tick();
   endtask

   task automatic test_late_cancel();
      write_reg(1'b1, 8'h01);
      write_reg(1'b0, 8'h01);
      strobe_ei();
      tick();
      tick();
      n_chk++; if (bus.int_vec !== 8'h40) begin n_err++; $display("FAIL late_vec_vblank: got %h want 40", bus.int_vec); end
      write_reg(1'b0, 8'h00);
      tick();
      n_chk++; if (bus.int_vec !== 8'h00) begin n_err++; $display("FAIL late_vec_zero: got %h want 00", bus.int_vec); end
      n_chk++; if (dbg_state !== S_REQ) begin n_err++; $display("FAIL late_stay_req: got %0d want 1", dbg_state); end
      n_chk++; if (bus.wake !== 1'b0) begin n_err++; $display("FAIL late_wake: got %b want 0", bus.wake); end
      strobe_ack();
      n_chk++; if (bus.int_vec !== 8'h00) begin n_err++; $display("FAIL late_vec_ack: got %h want 00", bus.int_vec); end
      read_reg(1'b1, 1'b0, rd);
      n_chk++; if (rd !== 8'hE1) begin n_err++; $display("FAIL late_if_kept: got %h want e1", rd); end
      tick();
   endtask

   task automatic test_set_wins();
      bus.irq_pulse = 5'b00001;
      write_reg(1'b1, 8'h00);
      bus.irq_pulse = 5'b00000;
      read_reg(1'b1, 1'b0, rd);
      n_chk++; if (rd !== 8'hE1) begin n_err++; $display("FAIL setwins_if: got %h want e1", rd); end
      write_reg(1'b1, 8'hFF);
      read_reg(1'b1, 1'b0, rd);
      n_chk++; if (rd !== 8'hFF) begin n_err++; $display("FAIL if_write_all: got %h want ff", rd); end
      write_reg(1'b1, 8'h00);
      read_reg(1'b1, 1'b0, rd);
      n_chk++; if (rd !== 8'hE0) begin n_err++; $display("FAIL if_write_zero: got %h want e0", rd); end
      write_reg(1'b0, 8'hA5);
      read_reg(1'b0, 1'b1, rd);
      n_chk++; if (rd !== 8'hA5) begin n_err++; $display("FAIL ie_rw: got %h want a5", rd); end
      write_reg(1'b0, 8'h00);
   endtask

   task automatic test_ei_timing();
      write_reg(1'b0, 8'h02);
      write_reg(1'b1, 8'h02);
      strobe_ei();
      n_chk++; if (bus.ime !== 1'b0) begin n_err++; $display("FAIL ei_edge1_ime: got %b want 0", bus.ime); end
      tick();
      n_chk++; if (bus.ime !== 1'b1) begin n_err++; $display("FAIL ei_edge2_ime: got %b want 1", bus.ime); end
      n_chk++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL ei_edge2_req: got %b want 0", bus.int_req); end
      tick();
      n_chk++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL ei_edge3_req: got %b want 1", bus.int_req); end
      strobe_ack();
      tick();
      write_reg(1'b1, 8'h02);
      bus.ei = 1'b1;
      bus.di = 1'b1;
      tick();
      bus.ei = 1'b0;
      bus.di = 1'b0;
      tick();
      tick();
      n_chk++; if (bus.ime !== 1'b0) begin n_err++; $display("FAIL ei_di_same: got %b want 0", bus.ime); end
      n_chk++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL ei_di_req: got %b want 0", bus.int_req); end
      strobe_ei();
      bus.di = 1'b1;
      tick();
      bus.di = 1'b0;
      tick();
      tick();
      n_chk++; if (bus.ime !== 1'b0) begin n_err++; $display("FAIL di_cancel_ei: got %b want 0", bus.ime); end
      strobe_ei();
      tick();
      tick();
      n_chk++; if (dbg_state !== S_REQ) begin n_err++; $display("FAIL di_pre_req: got %0d want 1", dbg_state); end
      bus.di = 1'b1;
      tick();
      bus.di = 1'b0;
      n_chk++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL di_abandon: got %0d want 0", dbg_state); end
      n_chk++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL di_req_drop: got %b want 0", bus.int_req); end
      read_reg(1'b1, 1'b0, rd);
      n_chk++; if (rd !== 8'hE2) begin n_err++; $display("FAIL di_if_kept: got %h want e2", rd); end
   endtask

   task automatic test_async_reset();
      strobe_ei();
      tick();
      tick();
      n_chk++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL arst_pre_req: got %b want 1", bus.int_req); end
      #2;
      reset = 1'b1;
      bus.int_ack = 1'b1;
      #1;
      n_chk++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL arst_req_now: got %b want 0", bus.int_req); end
      n_chk++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL arst_state_now: got %0d want 0", dbg_state); end
      tick();
      #2;
      reset = 1'b0;
      bus.int_ack = 1'b0;
      tick();
      n_chk++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL arst_state_after: got %0d want 0", dbg_state); end
      n_chk++; if (bus.ime !== 1'b0) begin n_err++; $display("FAIL arst_ime: got %b want 0", bus.ime); end
      n_chk++; if (bus.wake !== 1'b0) begin n_err++; $display("FAIL arst_wake: got %b want 0", bus.wake); end
      read_reg(1'b1, 1'b0, rd);
      n_chk++; if (rd !== 8'hE0) begin n_err++; $display("FAIL arst_if: got %h want e0", rd); end
      read_reg(1'b0, 1'b1, rd);
      n_chk++; if (rd !== 8'h00) begin n_err++; $display("FAIL arst_ie: got %h want 00", rd); end
   endtask

   initial begin
      n_chk         = 0;
      n_err         = 0;
      reset         = 1'b1;
      bus.irq_pulse = 5'b00000;
      bus.sel_if    = 1'b0;
      bus.sel_ie    = 1'b0;
      bus.wr_en     = 1'b0;
      bus.wr_data   = 8'h00;
      bus.ei        = 1'b0;
      bus.di        = 1'b0;
      bus.int_ack   = 1'b0;
      test_reset();
      test_basic_dispatch();
      test_priority();
      test_late_cancel();
      test_set_wins();
      test_ei_timing();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
